// File: rtl/vram_access_arbiter_if.sv
// Bundles the display read port, host write port and VRAM macro port of the
// VRAM access arbiter. The arbiter connects through the slave modport; the
// surrounding environment (display pipeline, host, memory) uses master.
interface vram_access_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    // display read port
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    // host write port
    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;

    // VRAM macro port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, host_valid, host_addr, host_wdata, mem_rdata,
        output disp_rvalid, disp_rdata, host_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, host_valid, host_addr, host_wdata, mem_rdata,
        input  disp_rvalid, disp_rdata, host_ready, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_access_arbiter.sv
// Shares a single-port synchronous VRAM between display reads (absolute
// priority) and buffered host writes, which drain in cycles the display
// leaves idle. With blank_only set, drains are confined to vertical blanking.
module vram_access_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int V_DISPLAY  = 480,
    parameter int V_MAX      = 524
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [9:0]                  hpos,
    input  logic [9:0]                  vpos,
    input  logic                        blank_only,
    vram_access_arbiter_if.slave        bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_start,
    output logic [15:0]                 stall_cycles
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL    = LVL_W'(FIFO_DEPTH);
    localparam logic [9:0]       V_DISPLAY_L = 10'(V_DISPLAY);
    localparam logic [9:0]       V_MAX_L     = 10'(V_MAX);

    typedef enum logic {
        ST_CLOSED = 1'b0,
        ST_OPEN   = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   drain_ok;
    logic   vblank;

    // host write FIFO storage and bookkeeping
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              fifo_empty, fifo_full;
    logic              push, pop;

    // VRAM address/data hold registers, read-valid, frame pulse, stall counter
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              disp_rvalid_q;
    logic              frame_start_q;
    logic              frame_origin;
    logic [15:0]       stall_q, stall_d;

    // Lines past the last frame line are treated as blanking as well.
    assign vblank       = (vpos >= V_DISPLAY_L) || (vpos > V_MAX_L);
    assign frame_origin = (hpos == 10'd0) && (vpos == 10'd0);

    assign fifo_empty     = (level_q == '0);
    assign fifo_full      = (level_q == FULL_LVL);
    assign bus.host_ready = !fifo_full && !reset;
    assign push           = bus.host_valid && bus.host_ready;

    // Arbiter state register: a one-cycle delayed view of the timing inputs,
    // so it carries no reset; it reloads every cycle, including during reset.
    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // Next-state: writes may drain when not restricted or in vertical blanking.
    always_comb begin
        state_d = ST_CLOSED;
        if (!blank_only || vblank) begin
            state_d = ST_OPEN;
        end
    end

    // State output decode.
    always_comb begin
        drain_ok = (state_q == ST_OPEN);
    end

    // Memory port mux: display read first, else drain the FIFO head when open.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        pop           = 1'b0;
        if (!reset) begin
            if (bus.disp_req) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.disp_addr;
            end else if (!fifo_empty && drain_ok) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = fifo_addr_q[rd_ptr_q];
                bus.mem_wdata = fifo_data_q[rd_ptr_q];
                pop           = 1'b1;
            end
        end
    end

    // FIFO pointer and level next-state.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // FIFO pointer and level registers; reset discards any pending writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // One storage slot per FIFO entry, written when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            // Capture the offered host write into this slot.
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    fifo_addr_q[gi] <= bus.host_addr;
                    fifo_data_q[gi] <= bus.host_wdata;
                end
            end
        end
    endgenerate

    // Hold the last driven VRAM address/data across idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (bus.mem_en) begin
            mem_addr_q  <= bus.mem_addr;
            mem_wdata_q <= bus.mem_wdata;
        end
    end

    // Stall counter next-state: frame origin clears, blocked drains count up.
    always_comb begin
        stall_d = stall_q;
        if (frame_origin) begin
            stall_d = 16'd0;
        end else if (!fifo_empty && !pop && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Read-valid pipeline, frame pulse and stall counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_rvalid_q <= 1'b0;
            frame_start_q <= 1'b0;
            stall_q       <= 16'd0;
        end else begin
            disp_rvalid_q <= bus.disp_req;
            frame_start_q <= frame_origin;
            stall_q       <= stall_d;
        end
    end

    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.disp_rdata  = bus.mem_rdata;
    assign fifo_level      = level_q;
    assign frame_start     = frame_start_q;
    assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Self-checking bench for vram_access_arbiter: directed vector table, hand
// sequences for multi-cycle corners, then randomized traffic against a
// queue-based reference model.
module tb_vram_access_arbiter;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       blank_only;
    logic [9:0] hpos, vpos;
    logic [2:0] fifo_level;
    logic       frame_start;
    logic [15:0] stall_cycles;

    vram_access_arbiter_if #(.ADDR_W(12), .DATA_W(8)) ifc ();

    vram_access_arbiter #(
        .ADDR_W(12), .DATA_W(8), .FIFO_DEPTH(DEPTH), .V_DISPLAY(480), .V_MAX(524)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hpos         (hpos),
        .vpos         (vpos),
        .blank_only   (blank_only),
        .bus          (ifc),
        .fifo_level   (fifo_level),
        .frame_start  (frame_start),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- VRAM device model (driven by the DUT) ----------------
    function automatic logic [7:0] init_val(input logic [11:0] a);
        return (a == 12'h123) ? 8'hA5 : (a[7:0] ^ 8'h5A);
    endfunction

    logic [7:0] dev_vram [0:4095];
    logic [7:0] mem_rdata_q;
    logic       mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) dev_vram[i] <= init_val(12'(i));
        end else if (ifc.mem_en) begin
            if (ifc.mem_we) dev_vram[ifc.mem_addr] <= ifc.mem_wdata;
            else            mem_rdata_q <= dev_vram[ifc.mem_addr];
        end
    end
    assign ifc.mem_rdata = mem_rdata_q;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        q[$];
    logic [7:0] ref_vram [0:4095];
    logic       m_open;
    logic       m_prev_req;
    logic [7:0] m_prev_rdata;
    logic       m_prev_frame;
    int         m_stall;
    logic [11:0] m_last_addr;
    logic [7:0]  m_last_wdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs against the model mid-cycle, then
    // advance the model with the inputs sampled at the rising edge.
    task automatic cycle();
        logic exp_pop;
        logic push_ok;
        logic sof;
        wr_t  w;
        @(negedge clk);
        exp_pop = 1'b0;
        if (reset) begin
            chk("rst_mem_en", 32'(ifc.mem_en), 32'd0);
            chk("rst_mem_we", 32'(ifc.mem_we), 32'd0);
            chk("rst_host_ready", 32'(ifc.host_ready), 32'd0);
        end else begin
            exp_pop = !ifc.disp_req && (q.size() > 0) && m_open;
            chk("mem_en", 32'(ifc.mem_en), 32'(ifc.disp_req || exp_pop));
            chk("mem_we", 32'(ifc.mem_we), 32'(exp_pop));
            chk("host_ready", 32'(ifc.host_ready), 32'(q.size() < DEPTH));
            chk("fifo_level", 32'(fifo_level), 32'(q.size()));
            chk("disp_rvalid", 32'(ifc.disp_rvalid), 32'(m_prev_req));
            if (m_prev_req) chk("disp_rdata", 32'(ifc.disp_rdata), 32'(m_prev_rdata));
            chk("frame_start", 32'(frame_start), 32'(m_prev_frame));
            chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
            if (ifc.disp_req) begin
                chk("mem_addr_rd", 32'(ifc.mem_addr), 32'(ifc.disp_addr));
            end else if (exp_pop) begin
                chk("mem_addr_wr", 32'(ifc.mem_addr), 32'(q[0].addr));
                chk("mem_wdata_wr", 32'(ifc.mem_wdata), 32'(q[0].data));
            end else begin
                chk("mem_addr_hold", 32'(ifc.mem_addr), 32'(m_last_addr));
                chk("mem_wdata_hold", 32'(ifc.mem_wdata), 32'(m_last_wdata));
            end
        end
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_stall      = 0;
            m_prev_req   = 1'b0;
            m_prev_frame = 1'b0;
            m_last_addr  = 12'd0;
            m_last_wdata = 8'd0;
        end else begin
            push_ok = ifc.host_valid && (q.size() < DEPTH);
            sof     = (hpos == 10'd0) && (vpos == 10'd0);
            if (sof) m_stall = 0;
            else if ((q.size() > 0) && !exp_pop && (m_stall < 65535)) m_stall++;
            if (ifc.disp_req) begin
                m_prev_rdata = ref_vram[ifc.disp_addr];
                m_last_addr  = ifc.disp_addr;
            end
            if (exp_pop) begin
                w = q.pop_front();
                ref_vram[w.addr] = w.data;
                m_last_addr  = w.addr;
                m_last_wdata = w.data;
            end
            if (push_ok) q.push_back('{addr: ifc.host_addr, data: ifc.host_wdata});
            m_prev_req   = ifc.disp_req;
            m_prev_frame = sof;
        end
        m_open = !blank_only || (vpos >= 10'd480);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.disp_req   = 1'b0;
        ifc.host_valid = 1'b0;
    endtask

    task automatic host_push(input logic [11:0] a, input logic [7:0] d);
        ifc.host_valid = 1'b1;
        ifc.host_addr  = a;
        ifc.host_wdata = d;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        req;
        logic        hv;
        logic [11:0] haddr;
        logic [7:0]  hdata;
        logic        exp_we;
        logic        exp_ready;
        logic [2:0]  exp_level;
        logic [11:0] exp_addr;
    } vec_t;

    vec_t vt [14];
    logic [5:0] pat;
    int mism;

    initial begin
        // display held for 10 cycles while the host offers 6 writes; then drain
        vt[0]  = '{1'b1, 1'b1, 12'h300, 8'h40, 1'b0, 1'b1, 3'd0, 12'h200};
        vt[1]  = '{1'b1, 1'b1, 12'h301, 8'h41, 1'b0, 1'b1, 3'd1, 12'h201};
        vt[2]  = '{1'b1, 1'b1, 12'h302, 8'h42, 1'b0, 1'b1, 3'd2, 12'h202};
        vt[3]  = '{1'b1, 1'b1, 12'h303, 8'h43, 1'b0, 1'b1, 3'd3, 12'h203};
        vt[4]  = '{1'b1, 1'b1, 12'h304, 8'h44, 1'b0, 1'b0, 3'd4, 12'h204};
        vt[5]  = '{1'b1, 1'b1, 12'h305, 8'h45, 1'b0, 1'b0, 3'd4, 12'h205};
        vt[6]  = '{1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 3'd4, 12'h206};
        vt[7]  = '{1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 3'd4, 12'h207};
        vt[8]  = '{1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 3'd4, 12'h208};
        vt[9]  = '{1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 3'd4, 12'h209};
        vt[10] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 3'd4, 12'h300};
        vt[11] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 3'd3, 12'h301};
        vt[12] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 3'd2, 12'h302};
        vt[13] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 3'd1, 12'h303};

        for (int i = 0; i < 4096; i++) ref_vram[i] = init_val(12'(i));
        mem_init = 1'b1;
        m_open = 1'b0; m_prev_req = 1'b0; m_prev_frame = 1'b0; m_stall = 0;
        m_last_addr = 12'd0; m_last_wdata = 8'd0; m_prev_rdata = 8'd0;

        // ---- 1: reset held two cycles with host_valid high ----
        reset = 1'b1; blank_only = 1'b0; hpos = 10'd5; vpos = 10'd10;
        ifc.disp_req = 1'b0; ifc.disp_addr = 12'd0;
        host_push(12'h010, 8'h3C);
        for (int k = 0; k < 2; k++) begin
            #3;
            chk("reset_host_ready", 32'(ifc.host_ready), 32'd0);
            chk("reset_mem_en", 32'(ifc.mem_en), 32'd0);
            cycle();
            mem_init = 1'b0;
        end
        reset = 1'b0;
        #3;
        chk("first_ready", 32'(ifc.host_ready), 32'd1);
        cycle();
        ifc.host_valid = 1'b0;
        #3;
        chk("first_level", 32'(fifo_level), 32'd1);
        chk("first_we", 32'(ifc.mem_we), 32'd1);
        chk("first_addr", 32'(ifc.mem_addr), 32'h010);
        chk("first_wdata", 32'(ifc.mem_wdata), 32'h3C);
        cycle();
        $display("seq reset_release: first host write issued");

        // ---- 2: vector table, display blocking then draining ----
        for (int i = 0; i < 14; i++) begin
            ifc.disp_req   = vt[i].req;
            ifc.disp_addr  = 12'h200 + 12'(i);
            ifc.host_valid = vt[i].hv;
            ifc.host_addr  = vt[i].haddr;
            ifc.host_wdata = vt[i].hdata;
            #3;
            chk("tbl_mem_we", 32'(ifc.mem_we), 32'(vt[i].exp_we));
            chk("tbl_host_ready", 32'(ifc.host_ready), 32'(vt[i].exp_ready));
            chk("tbl_level", 32'(fifo_level), 32'(vt[i].exp_level));
            chk("tbl_mem_addr", 32'(ifc.mem_addr), 32'(vt[i].exp_addr));
            if (i == 10) chk("tbl_stall", 32'(stall_cycles), 32'd9);
            cycle();
        end
        idle_inputs();
        $display("seq display_block: 4 of 6 writes accepted and drained");

        // ---- 3: read latency and alternating read/idle ----
        ifc.disp_req = 1'b1; ifc.disp_addr = 12'h123;
        cycle();
        ifc.disp_req = 1'b0;
        #3;
        chk("rd_rvalid", 32'(ifc.disp_rvalid), 32'd1);
        chk("rd_rdata", 32'(ifc.disp_rdata), 32'hA5);
        cycle();
        for (int k = 0; k < 8; k++) begin
            ifc.disp_req  = (k % 2 == 0);
            ifc.disp_addr = 12'h120 + 12'(k);
            if (k < 3) host_push(12'h500 + 12'(k), 8'h60 + 8'(k));
            else ifc.host_valid = 1'b0;
            #3;
            if (ifc.disp_req) chk("alt_no_we_on_read", 32'(ifc.mem_we), 32'd0);
            cycle();
        end
        idle_inputs();
        cycle();
        $display("seq read_interleave: reads and writes interleaved");

        // ---- 4: tear-free mode, drains wait for vblank ----
        blank_only = 1'b1; vpos = 10'd100;
        cycle();
        for (int k = 0; k < 3; k++) begin
            host_push(12'h400 + 12'(k), 8'h90 + 8'(k));
            cycle();
        end
        ifc.host_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("closed_no_we", 32'(ifc.mem_we), 32'd0);
            cycle();
        end
        chk("closed_level", 32'(fifo_level), 32'd3);
        vpos = 10'd480;
        for (int k = 0; k < 6; k++) begin
            #3;
            pat[k] = ifc.mem_we;
            cycle();
        end
        chk("blank_drain_pattern", 32'(pat), 32'h0E);
        $display("seq blank_only: 3 writes drained in vblank");

        // ---- 5: frame start pulse and stall clear ----
        vpos = 10'd100;
        host_push(12'h600, 8'hC1);
        cycle();
        ifc.host_valid = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        hpos = 10'd0; vpos = 10'd0;
        #3;
        chk("pre_frame_start", 32'(frame_start), 32'd0);
        cycle();
        hpos = 10'd1;
        #3;
        chk("frame_start_pulse", 32'(frame_start), 32'd1);
        chk("frame_stall_clear", 32'(stall_cycles), 32'd0);
        cycle();
        hpos = 10'd2;
        #3;
        chk("frame_start_drop", 32'(frame_start), 32'd0);
        chk("frame_stall_resume", 32'(stall_cycles), 32'd1);
        cycle();
        blank_only = 1'b0; hpos = 10'd5; vpos = 10'd10;
        for (int k = 0; k < 3; k++) cycle();
        $display("seq frame_start: single pulse, stall cleared");

        // ---- 6: reset while writes are pending ----
        blank_only = 1'b1; vpos = 10'd100;
        cycle();
        for (int k = 0; k < 3; k++) begin
            host_push(12'hA00 + 12'(k), 8'hE0 + 8'(k));
            cycle();
        end
        ifc.host_valid = 1'b0;
        #3;
        chk("pre_reset_level", 32'(fifo_level), 32'd3);
        reset = 1'b1; blank_only = 1'b0;
        #1;
        chk("reset_drain_we", 32'(ifc.mem_we), 32'd0);
        cycle();
        reset = 1'b0;
        #3;
        chk("post_reset_level", 32'(fifo_level), 32'd0);
        host_push(12'h7AB, 8'h5D);
        cycle();
        ifc.host_valid = 1'b0;
        #3;
        chk("post_reset_we", 32'(ifc.mem_we), 32'd1);
        chk("post_reset_addr", 32'(ifc.mem_addr), 32'h7AB);
        cycle();
        $display("seq reset_mid_drain: pending writes discarded");

        // ---- 7: randomized traffic against the reference model ----
        hpos = 10'd0; vpos = 10'd520;
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 63) == 0) blank_only = ~blank_only;
            ifc.disp_req   = 1'($urandom_range(0, 1));
            ifc.disp_addr  = 12'($urandom);
            ifc.host_valid = 1'($urandom_range(0, 1));
            ifc.host_addr  = 12'($urandom);
            ifc.host_wdata = 8'($urandom);
            cycle();
            if (hpos == 10'd7) begin
                hpos = 10'd0;
                vpos = (vpos == 10'd524) ? 10'd0 : vpos + 10'd1;
            end else begin
                hpos = hpos + 10'd1;
            end
        end
        reset = 1'b0; blank_only = 1'b0; idle_inputs();
        for (int k = 0; k < 6; k++) cycle();
        $display("seq random: 4000 cycles of mixed traffic");

        // final VRAM image must match the model's ordered, exactly-once writes
        mism = 0;
        for (int i = 0; i < 4096; i++) if (dev_vram[i] !== ref_vram[i]) mism++;
        chk("vram_image", 32'(mism), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
